uart_xmit_cfg: RTL and testbench

UART_XMIT_CFG -- requirements
Module: uart_xmit_cfg

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_xmit_cfg.sv | 178 +++++++++++++++++
 tb/tb_uart_xmit_cfg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and helpers for the configurable UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Wide enough to index up to 9 payload bits or 2 stop bits.
  localparam int unsigned C_BIT_CNT_W = 4;

  // Takes the XOR of the payload and returns the bit to put on the line.
  function automatic logic parity_bit(input logic xor_of_data, input parity_t mode);
    return (mode == PAR_ODD) ? ~xor_of_data : xor_of_data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period timer; one-cycle tick every CLKS_PER_BIT clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned C_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [C_W-1:0] C_LAST = C_W'(CLKS_PER_BIT - 1);

  logic [C_W-1:0] cnt_q;
  logic [C_W-1:0] cnt_d;

  // Held at zero while cleared so the first bit of a frame gets a full period.
  assign tick = !clr && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + C_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_xmit_cfg.sv
// ============================================================================
// Module   : uart_xmit_cfg
// Purpose  : Configurable UART transmitter; UART_XMIT_FIFO_EN adds a TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import uart_pkg::*;

module uart_xmit_cfg #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_t     PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk100MHz,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [C_BIT_CNT_W-1:0] C_LAST_DATA = C_BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [C_BIT_CNT_W-1:0] C_LAST_STOP = C_BIT_CNT_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      CLKS_PER_BIT < 1) begin : g_bad_cfg
    $error("uart_xmit_cfg: illegal parameter combination");
  end

  state_t                   state_q, state_d;
  logic [C_BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]     sh_q, sh_d;
  logic                     par_q, par_d;
  logic                     txd_q, txd_d;

  logic                     w_tick;
  logic                     w_avail;
  logic                     w_load;
  logic [DATA_BITS-1:0]     w_word;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk100MHz),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (w_tick)
  );

`ifdef UART_XMIT_FIFO_EN
  localparam int unsigned C_AW = $clog2(FIFO_DEPTH);
  localparam logic [C_AW:0] C_DEPTH = (C_AW + 1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [C_AW:0]        wptr_q, rptr_q;
  logic                 w_full;
  logic                 w_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_full  = (wptr_q - rptr_q) == C_DEPTH;
  assign rdy     = rst && !w_full;
  assign w_push  = valid && rdy;
  assign w_avail = (wptr_q != rptr_q);
  assign w_word  = mem_q[rptr_q[C_AW-1:0]];

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + (C_AW + 1)'(1);
      if (w_load) rptr_q <= rptr_q + (C_AW + 1)'(1);
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (w_push) mem_q[wptr_q[C_AW-1:0]] <= data;
  end
`else
  // Without a FIFO the shift register is the only storage: one word per frame.
  assign rdy     = rst && (state_q == IDLE);
  assign w_avail = valid && rdy;
  assign w_word  = data;
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    w_load  = 1'b0;
    txd_d   = 1'b1;

    case (state_q)
      IDLE: begin
        if (w_avail) w_load = 1'b1;
      end
      START: begin
        if (w_tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (bit_q == C_LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY == PAR_NONE) ? STOP : PAR;
          end else begin
            bit_d = bit_q + C_BIT_CNT_W'(1);
            sh_d  = sh_q >> 1;
          end
        end
      end
      PAR: begin
        if (w_tick) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (bit_q == C_LAST_STOP) begin
            if (w_avail) w_load = 1'b1;
            else         state_d = IDLE;
          end else begin
            bit_d = bit_q + C_BIT_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_load) begin
      state_d = START;
      bit_d   = '0;
      sh_d    = w_word;
      par_d   = parity_bit(^w_word, PARITY);
    end

    // Line level follows the next state so txd is a clean register output.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_xmit_cfg.sv
// ============================================================================
// Module   : tb_uart_xmit_cfg
// Purpose  : Self-checking bench for uart_xmit_cfg (8N1, 8E1, 8O1, 7N2 at 10 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_xmit_cfg;
  import uart_pkg::*;

  localparam int CPB = 10;
`ifdef UART_XMIT_FIFO_EN
  localparam int LAT  = 2;
  localparam bit HOLD = 1'b0;
`else
  localparam int LAT  = 1;
  localparam bit HOLD = 1'b1;
`endif
  localparam int NB [4] = '{8, 8, 8, 7};
  localparam int PM [4] = '{0, 2, 1, 0};  // 0 none, 1 odd, 2 even
  localparam int NS [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid_v;
  logic [3:0] rdy_v;
  logic [3:0] txd_v;
  logic [3:0] busy_v;
  logic [8:0] data_v [4];

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];

`ifdef UART_XMIT_FIFO_EN
  logic [8:0] acc_q[$];
  logic       cap_q[$];
  logic       strm_q[$];
  logic       saw_full;
  int         first;
`endif

  always #5 clk = ~clk;

  uart_xmit_cfg #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut0 (
    .clk100MHz(clk), .rst(rst), .valid(valid_v[0]), .data(data_v[0][7:0]),
    .rdy(rdy_v[0]), .txd(txd_v[0]), .busy(busy_v[0]));

  uart_xmit_cfg #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
                  .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut1 (
    .clk100MHz(clk), .rst(rst), .valid(valid_v[1]), .data(data_v[1][7:0]),
    .rdy(rdy_v[1]), .txd(txd_v[1]), .busy(busy_v[1]));

  uart_xmit_cfg #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
                  .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut2 (
    .clk100MHz(clk), .rst(rst), .valid(valid_v[2]), .data(data_v[2][7:0]),
    .rdy(rdy_v[2]), .txd(txd_v[2]), .busy(busy_v[2]));

  uart_xmit_cfg #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(7),
                  .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut3 (
    .clk100MHz(clk), .rst(rst), .valid(valid_v[3]), .data(data_v[3][6:0]),
    .rdy(rdy_v[3]), .txd(txd_v[3]), .busy(busy_v[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mask_of(input int k);
    return 9'((1 << NB[k]) - 1);
  endfunction

  // Reference frame: start, payload LSB first, optional parity, stop bits.
  task automatic build(input int k, input logic [8:0] w);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < NB[k]; i++) begin
      exp_q.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (PM[k] == 2) exp_q.push_back(1'((ones % 2) == 1));
    if (PM[k] == 1) exp_q.push_back(1'((ones % 2) == 0));
    for (int s = 0; s < NS[k]; s++) exp_q.push_back(1'b1);
  endtask

  // Offers w to instance k and checks the line cycle by cycle.
  // abort_at >= 0 returns at that cycle offset from the start bit.
  task automatic run_frame(input int k, input logic [8:0] w, input bit hold, input int abort_at);
    int t;
    build(k, w);
    chk($sformatf("rdy_pre k%0d", k), rdy_v[k], 1'b1);
    valid_v[k] = 1'b1;
    data_v[k]  = w;
    @(negedge clk);
    valid_v[k] = hold;
    data_v[k]  = 9'($urandom) & mask_of(k);
    for (int i = 1; i < LAT; i++) begin
      chk($sformatf("txd_lat k%0d", k), txd_v[k], 1'b1);
      @(negedge clk);
    end
    t = 0;
    foreach (exp_q[b]) begin
      for (int c = 0; c < CPB; c++) begin
        if (t == abort_at) return;
        chk($sformatf("txd k%0d t%0d", k, t), txd_v[k], exp_q[b]);
        chk($sformatf("busy k%0d t%0d", k, t), busy_v[k], 1'b1);
`ifndef UART_XMIT_FIFO_EN
        chk($sformatf("rdy_busy k%0d t%0d", k, t), rdy_v[k], 1'b0);
`endif
        data_v[k] = 9'($urandom) & mask_of(k);
        t++;
        @(negedge clk);
      end
    end
    chk($sformatf("txd_end k%0d", k), txd_v[k], 1'b1);
    chk($sformatf("busy_end k%0d", k), busy_v[k], 1'b0);
  endtask

  initial begin
    rst     = 1'b0;
    valid_v = '0;
    for (int k = 0; k < 4; k++) data_v[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_txd k%0d", k), txd_v[k], 1'b1);
      chk($sformatf("rst_busy k%0d", k), busy_v[k], 1'b0);
      chk($sformatf("rst_rdy k%0d", k), rdy_v[k], 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("rel_rdy k%0d", k), rdy_v[k], 1'b1);

    // Directed frames: 8N1 A5, 8E1 A5, 8O1 A5, 7N2 7F.
    run_frame(0, 9'h0A5, 1'b0, -1);
    run_frame(1, 9'h0A5, 1'b0, -1);
    run_frame(2, 9'h0A5, 1'b0, -1);
    run_frame(3, 9'h07F, 1'b0, -1);

    // valid held high across a frame: next word waits for the stop bits.
    run_frame(0, 9'($urandom) & mask_of(0), HOLD, -1);
    run_frame(0, 9'($urandom) & mask_of(0), 1'b0, -1);
    run_frame(3, 9'($urandom) & mask_of(3), HOLD, -1);
    run_frame(3, 9'($urandom) & mask_of(3), 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) run_frame(k, 9'($urandom) & mask_of(k), 1'b0, -1);
    end

    // Reset in the middle of data bit 4, then a fresh 0x3C frame.
    run_frame(0, 9'h0A5, 1'b0, 55);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_txd", txd_v[0], 1'b1);
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_rdy", rdy_v[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rel_rdy", rdy_v[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_idle_txd", txd_v[0], 1'b1);
      chk("abort_idle_busy", busy_v[0], 1'b0);
      @(negedge clk);
    end
    run_frame(0, 9'h03C, 1'b0, -1);

`ifdef UART_XMIT_FIFO_EN
    // Push until full, then decode the contiguous stream against the queue.
    saw_full   = 1'b0;
    valid_v[0] = 1'b1;
    data_v[0]  = 9'($urandom) & mask_of(0);
    for (int t = 0; t < 1800; t++) begin
      cap_q.push_back(txd_v[0]);
      if (valid_v[0] && rdy_v[0]) begin
        acc_q.push_back(data_v[0]);
        data_v[0] = 9'($urandom) & mask_of(0);
      end else if (valid_v[0]) begin
        saw_full = 1'b1;
      end
      if (t == 19) valid_v[0] = 1'b0;
      @(negedge clk);
    end
    chk("fifo_full_seen", saw_full, 1'b1);
    chk("fifo_accepts", 1'(acc_q.size() >= 16), 1'b1);
    foreach (acc_q[i]) begin
      build(0, acc_q[i]);
      foreach (exp_q[b]) for (int c = 0; c < CPB; c++) strm_q.push_back(exp_q[b]);
    end
    first = -1;
    foreach (cap_q[i]) if (first < 0 && cap_q[i] == 1'b0) first = i;
    chk("fifo_start_found", 1'(first >= 0), 1'b1);
    if (first >= 0) begin
      for (int i = 0; i < strm_q.size(); i++)
        chk($sformatf("fifo_stream i%0d", i),
            (first + i < cap_q.size()) ? cap_q[first + i] : 1'bx, strm_q[i]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
